// File: rtl/reg_file_sb.sv
// Multi-read-port register file with busy-bit scoreboard and write-to-read bypass.
// Writes clear busy, allocs set it (alloc wins), flush clears all busy bits except a same-cycle alloc.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_addr,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic                    flush,
    output logic [NREGS-1:0]        busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_wr_ok;
    logic             w_alloc_ok;
    logic [AW-1:0]    w_ra;

    // Entry 0 is never written when hardwired to zero, so its flops stay at reset value.
    assign w_wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end
        if (w_wr_ok) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_alloc_ok) begin
            w_busy_nxt[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_ra    = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            w_ra = rd_addr[i*AW +: AW];
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == w_ra)) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
                rd_busy[i]              = 1'b0;
            end else begin
                rd_data[i*XLEN +: XLEN] = r_regs[w_ra];
                rd_busy[i]              = r_busy[w_ra];
            end
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: default instance plus a 16x64, 4-port, no-zero-reg, no-bypass instance,
// both driven from one abstract stimulus stream and checked against an array-based model.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // abstract stimulus shared by both instances
    logic        ae, we, fl;
    int          aa, wa;
    logic [63:0] wd;
    int          ra [4];

    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [31:0]  a_busy_vec;
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [15:0]  b_busy_vec;

    assign a_rd_addr = {ra[1][4:0], ra[0][4:0]};
    assign b_rd_addr = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

    reg_file_sb u_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .alloc_en(ae), .alloc_addr(aa[4:0]),
        .wr_en(we), .wr_addr(wa[4:0]), .wr_data(wd[31:0]),
        .flush(fl), .busy_vec(a_busy_vec)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .alloc_en(ae), .alloc_addr(aa[3:0]),
        .wr_en(we), .wr_addr(wa[3:0]), .wr_data(wd),
        .flush(fl), .busy_vec(b_busy_vec)
    );

    // reference model: architectural register values and pending-writer flags per instance
    int          zr    [2] = '{1, 0};
    int          byp   [2] = '{1, 0};
    int          amask [2] = '{31, 15};
    int          nrd   [2] = '{2, 4};
    logic [63:0] m_regs [2][32];
    logic        m_busy [2][32];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [63:0] dmask(int k);
        return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] exp_data(int k, int a);
        if (zr[k] != 0 && a == 0) return 64'h0;
        if (byp[k] != 0 && we && (wa & amask[k]) == a) return wd & dmask(k);
        return m_regs[k][a];
    endfunction

    function automatic logic exp_busy(int k, int a);
        if (zr[k] != 0 && a == 0) return 1'b0;
        if (byp[k] != 0 && we && (wa & amask[k]) == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 32; j++) begin
                m_regs[k][j] = 64'h0;
                m_busy[k][j] = 1'b0;
            end
    endtask

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            int w = wa & amask[k];
            int al = aa & amask[k];
            if (fl)
                for (int j = 0; j < 32; j++) m_busy[k][j] = 1'b0;
            if (we && !(zr[k] != 0 && w == 0)) begin
                m_regs[k][w] = wd & dmask(k);
                m_busy[k][w] = 1'b0;
            end
            if (ae && !(zr[k] != 0 && al == 0)) m_busy[k][al] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [63:0] ev;
            for (int p = 0; p < nrd[k]; p++) begin
                int a = ra[p] & amask[k];
                if (k == 0) begin
                    chk($sformatf("a_data p%0d r%0d", p, a), {32'h0, a_rd_data[p*32 +: 32]}, exp_data(k, a));
                    chk($sformatf("a_busy p%0d r%0d", p, a), {63'h0, a_rd_busy[p]}, {63'h0, exp_busy(k, a)});
                end else begin
                    chk($sformatf("b_data p%0d r%0d", p, a), b_rd_data[p*64 +: 64], exp_data(k, a));
                    chk($sformatf("b_busy p%0d r%0d", p, a), {63'h0, b_rd_busy[p]}, {63'h0, exp_busy(k, a)});
                end
            end
            ev = 64'h0;
            for (int j = 0; j <= amask[k]; j++) ev[j] = m_busy[k][j];
            if (k == 0) chk("a_busy_vec", {32'h0, a_busy_vec}, ev);
            else        chk("b_busy_vec", {48'h0, b_busy_vec}, ev);
        end
    endtask

    task automatic drive(input logic iae, input int iaa, input logic iwe, input int iwa,
                         input logic [63:0] iwd, input logic ifl,
                         input int r0, input int r1, input int r2, input int r3);
        ae = iae; aa = iaa; we = iwe; wa = iwa; wd = iwd; fl = ifl;
        ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
    endtask

    task automatic settle();
        #4;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
        model_reset();

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 check_all();
        chk("reset_a_busy_vec", {32'h0, a_busy_vec}, 64'h0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 0, 64'h0, 0, i, i, i, i);
            settle();
            chk("post_reset_zero", {32'h0, a_rd_data[31:0]}, 64'h0);
            tick();
        end

        // write with same-cycle bypass (a) vs. old value (b)
        drive(0, 0, 1, 5, 64'hDEAD_BEEF, 0, 5, 5, 5, 5);
        settle();
        chk("bypass_r5", {32'h0, a_rd_data[31:0]}, 64'hDEAD_BEEF);
        chk("nobypass_r5_old", b_rd_data[63:0], 64'h0);
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 5, 5, 5, 5);
        settle();
        chk("nobypass_r5_new", b_rd_data[63:0], 64'hDEAD_BEEF);
        tick();

        // r0 hardwired on a, writable on b
        drive(0, 0, 1, 0, 64'h1234, 0, 0, 0, 0, 0);
        settle();
        chk("r0_zero_bypass", {32'h0, a_rd_data[31:0]}, 64'h0);
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
        settle();
        chk("r0_zero", {32'h0, a_rd_data[31:0]}, 64'h0);
        chk("b_r0_written", b_rd_data[63:0], 64'h1234);
        tick();

        // scoreboard on r7
        drive(1, 7, 0, 0, 64'h0, 0, 7, 7, 7, 7);
        settle();
        chk("alloc_no_same_cycle", {63'h0, a_rd_busy[0]}, 64'h0);
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 7, 7, 7, 7);
        settle();
        chk("r7_busy", {63'h0, a_rd_busy[0]}, 64'h1);
        chk("r7_busy_vec", {63'h0, a_busy_vec[7]}, 64'h1);
        tick();
        drive(0, 0, 1, 7, 64'h55, 0, 7, 7, 7, 7);
        settle();
        chk("r7_bypass_busy", {63'h0, a_rd_busy[0]}, 64'h0);
        chk("r7_bypass_data", {32'h0, a_rd_data[31:0]}, 64'h55);
        chk("b_r7_still_busy", {63'h0, b_rd_busy[0]}, 64'h1);
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 7, 7, 7, 7);
        settle();
        chk("r7_busy_cleared", {63'h0, a_busy_vec[7]}, 64'h0);
        tick();

        // alloc/write collision on r9
        drive(1, 9, 1, 9, 64'hAA, 0, 9, 9, 9, 9);
        settle();
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 9, 9, 9, 9);
        settle();
        chk("r9_data", {32'h0, a_rd_data[31:0]}, 64'hAA);
        chk("r9_busy_vec", {63'h0, a_busy_vec[9]}, 64'h1);
        tick();

        // flush with concurrent alloc and write
        drive(1, 3, 0, 0, 64'h0, 0, 3, 4, 6, 10); settle(); tick();
        drive(1, 4, 0, 0, 64'h0, 0, 3, 4, 6, 10); settle(); tick();
        drive(1, 6, 0, 0, 64'h0, 0, 3, 4, 6, 10); settle(); tick();
        drive(1, 10, 1, 4, 64'h77, 1, 4, 3, 6, 10);
        settle();
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 4, 3, 6, 10);
        settle();
        chk("flush_a_busy_vec", {32'h0, a_busy_vec}, 64'h400);
        chk("flush_b_busy_vec", {48'h0, b_busy_vec}, 64'h400);
        chk("flush_r4", {32'h0, a_rd_data[31:0]}, 64'h77);
        chk("flush_b_r4", b_rd_data[63:0], 64'h77);
        tick();

        // wide instance: four ports on r0, r15, r15, r8
        drive(0, 0, 1, 15, 64'hFEDC_BA98_7654_3210, 0, 0, 15, 15, 8); settle(); tick();
        drive(0, 0, 1, 8, 64'h0123_4567_89AB_CDEF, 0, 0, 15, 15, 8); settle(); tick();
        drive(1, 0, 0, 0, 64'h0, 0, 0, 15, 15, 8); settle(); tick();
        drive(0, 0, 0, 0, 64'h0, 0, 0, 15, 15, 8);
        settle();
        chk("b_p0_r0", b_rd_data[63:0], 64'h1234);
        chk("b_p1_r15", b_rd_data[127:64], 64'hFEDC_BA98_7654_3210);
        chk("b_p2_r15", b_rd_data[191:128], 64'hFEDC_BA98_7654_3210);
        chk("b_p3_r8", b_rd_data[255:192], 64'h0123_4567_89AB_CDEF);
        chk("b_r0_busy", {63'h0, b_busy_vec[0]}, 64'h1);
        chk("a_r0_never_busy", {63'h0, a_busy_vec[0]}, 64'h0);
        tick();

        // randomized traffic with one mid-run reset
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 3), $urandom_range(0, 31),
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 31),
                  {$urandom, $urandom}, ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31));
            settle();
            if (c == 200) begin
                rst_n = 1'b0;
                model_reset();
                #1 check_all();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port integer register file with a built-in busy-bit scoreboard and write-to-read bypass. It replaces the single-purpose 32x32 register array in the core's decode/writeback path: clocked writes, any number of combinational read ports, a hardwired zero register, and per-register "pending writer" tracking. Issue logic uses it to detect RAW hazards. Flush support lets the pipeline discard in-flight producers after a redirect.

## Interface

Parameters:
- `XLEN`, default 32: register data width.
- `NREGS`, default 32: number of architectural registers. Must be a power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `NREAD`, default 2: number of read ports, ≥ 1.
- `ZERO_REG`, default 1: when 1, register 0 reads as zero, ignores writes and is never busy.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `rd_addr` in, NREAD*AW: read addresses; port i is `[i*AW +: AW]`.
- `rd_data` out, NREAD*XLEN: read data; port i is `[i*XLEN +: XLEN]`.
- `rd_busy` out, NREAD: port i's register has an outstanding writer.
- `alloc_en` in, 1: issue stage claims `alloc_addr` as a destination.
- `alloc_addr` in, AW: register to mark busy.
- `wr_en` in, 1: writeback valid.
- `wr_addr` in, AW: writeback register.
- `wr_data` in, XLEN: writeback data.
- `flush` in, 1: clear all busy bits (pipeline redirect).
- `busy_vec` out, NREGS: full scoreboard state, registered.

## Operation

- Storage is `NREGS` x `XLEN` flops. When `ZERO_REG`=1, entry 0 is not implemented and is treated as constant 0.
- Write: at a rising edge with `wr_en`=1, `regs[wr_addr] <= wr_data` and `busy[wr_addr] <= 0`. This is skipped for `wr_addr`=0 when `ZERO_REG`=1.
- Alloc: at a rising edge with `alloc_en`=1, `busy[alloc_addr] <= 1`. This is skipped for address 0 when `ZERO_REG`=1.
- Read port i, combinational, evaluated in priority order:
  1. If `ZERO_REG`=1 and addr=0: `rd_data`=0, `rd_busy`=0.
  2. Else if `BYPASS`=1 and `wr_en` and `wr_addr`==addr: `rd_data`=`wr_data`, `rd_busy`=0.
  3. Else: `rd_data`=`regs[addr]`, `rd_busy`=`busy[addr]`.
- Simultaneous alloc and write to the same register: the alloc wins and busy ends at 1, because a new producer has been issued. Data is still written.
- Flush: at the next edge every busy bit clears, except a same-cycle `alloc_en`, which sets its bit (alloc wins over flush). A same-cycle write is still performed. Register contents are never affected by flush.
- Alloc of an already-busy register leaves it busy; there is no counting. Write to a non-busy register is legal and just updates data.
- `busy_vec` mirrors the busy flops directly, with no bypass. Bit 0 is constant 0 when `ZERO_REG`=1.

## Timing

- Reset (`rst_n`=0, asynchronous assert) clears all registers and busy bits to 0 immediately, independent of `clk`. Consequently `rd_data`=0, `rd_busy`=0 and `busy_vec`=0 for any address, except where a same-cycle bypass applies.
- Reset deassertion is synchronised externally; the first edge after release performs normal updates.
- Write latency: 1 cycle into storage. With `BYPASS`=1 the effective read latency is 0 cycles: same-cycle forwarding.
- Alloc latency: the busy bit becomes visible on `rd_busy`/`busy_vec` the cycle after `alloc_en`. There is no same-cycle visibility.
- With `BYPASS`=0, a read of the register being written returns the old value and old busy state in that cycle, and the new value from the next cycle.
- Reset asserted mid-operation discards pending allocs and writes; there is no partial state.
- Reads have no side effects; any number of ports may address the same register.

## Test plan

- **Reset:** drive `rst_n`=0 between clock edges → all `rd_data`=0 and `busy_vec`=0 immediately. Release, read regs 1..31 → all 0.
- **Write/read/bypass:** write 0xDEADBEEF to r5. In that same cycle `rd_addr` port0=5 → `rd_data`=0xDEADBEEF (`BYPASS`=1). With `BYPASS`=0 it returns old 0, then 0xDEADBEEF next cycle. Write 0x1234 to r0 → r0 still reads 0.
- **Scoreboard:** alloc r7 → next cycle `rd_busy`=1 and `busy_vec[7]`=1. Write r7=0x55 → same cycle `rd_busy`=0 via bypass; next cycle `busy_vec[7]`=0.
- **Alloc/write collision:** alloc r9 and write r9=0xAA in the same cycle → next cycle r9 reads 0xAA and `busy_vec[9]`=1.
- **Flush:** alloc r3, r4, r6 over three cycles. Then assert `flush` together with alloc r10 and write r4=0x77 → next cycle `busy_vec` has only bit 10 set, r4=0x77, and r3/r6 data unchanged.
- **Parameter sweep:** run NREGS=16, NREAD=4, XLEN=64 and ZERO_REG=0 → 4 ports reading r0, r15, r15, r8 all return correct 64-bit data. r0 is writable and allocatable when ZERO_REG=0.
